// File: rtl/axi_ram_pkg.sv
// Shared helpers for the RAM command back end: constant log2 and derived widths.
package axi_ram_pkg;

   // Width of a response entry {id, data, last} and of a 0..depth counter.
   localparam int unsigned RESP_W = 8 + 32 + 1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic int unsigned resp_w(input int unsigned id_w, input int unsigned data_w);
      return id_w + data_w + 1;
   endfunction

   function automatic int unsigned cred_w(input int unsigned depth);
      return clog2(depth + 1);
   endfunction

endpackage

// File: rtl/axi_ram_cmd_mem_if.sv
// Command stream from the arbiter and read response stream back to it.
interface axi_ram_cmd_mem_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned ID_WIDTH   = 8
) ();
   logic [ID_WIDTH-1:0]       cmd_id;
   logic [ADDR_WIDTH-1:0]     cmd_addr;
   logic [DATA_WIDTH-1:0]     cmd_wr_data;
   logic [DATA_WIDTH/8-1:0]   cmd_wr_strb;
   logic                      cmd_wr_en;
   logic                      cmd_rd_en;
   logic                      cmd_last;
   logic                      cmd_ready;
   logic [ID_WIDTH-1:0]       rd_resp_id;
   logic [DATA_WIDTH-1:0]     rd_resp_data;
   logic                      rd_resp_last;
   logic                      rd_resp_valid;
   logic                      rd_resp_ready;

   modport master (
      output cmd_id, cmd_addr, cmd_wr_data, cmd_wr_strb, cmd_wr_en, cmd_rd_en, cmd_last,
      input  cmd_ready,
      input  rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid,
      output rd_resp_ready
   );

   modport slave (
      input  cmd_id, cmd_addr, cmd_wr_data, cmd_wr_strb, cmd_wr_en, cmd_rd_en, cmd_last,
      output cmd_ready,
      output rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid,
      input  rd_resp_ready
   );
endinterface

// File: rtl/axi_ram_resp_fifo.sv
// Synchronous response FIFO with a registered output stage; a push into an empty
// FIFO appears on the output one edge later.
module axi_ram_resp_fifo
   import axi_ram_pkg::*;
#(
   parameter int unsigned WIDTH = RESP_W,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);
   localparam int unsigned PW = clog2(DEPTH);
   localparam int unsigned CW = clog2(DEPTH + 1);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             pop, load, st_push, st_pop;
   logic [WIDTH-1:0] load_data;

   // Refill the output register from storage first (older), else bypass the push.
   always_comb begin
      pop       = out_valid && out_ready;
      load      = 1'b0;
      st_pop    = 1'b0;
      st_push   = push;
      load_data = push_data;
      if (!out_valid || pop) begin
         if (cnt_q != '0) begin
            load      = 1'b1;
            st_pop    = 1'b1;
            load_data = store[rptr_q];
         end else if (push) begin
            load    = 1'b1;
            st_push = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (st_push) store[wptr_q] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
      end else begin
         if (load) out_data <= load_data;
         out_valid <= load || (out_valid && !pop);
         if (st_push) wptr_q <= wptr_q + PW'(1);
         if (st_pop)  rptr_q <= rptr_q + PW'(1);
         case ({st_push, st_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end
endmodule

// File: rtl/axi_ram_cmd_mem.sv
// RAM back end for the arbitrated command stream: byte-masked writes, pipelined
// reads, and a credit-protected in-order read response FIFO.
module axi_ram_cmd_mem
   import axi_ram_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ADDR_WIDTH      = 16,
   parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH        = 8,
   parameter int unsigned READ_LATENCY    = 2,
   parameter int unsigned RESP_FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   axi_ram_cmd_mem_if.slave bus,
   output logic             err_collide
);
   localparam int unsigned LSB    = clog2(STRB_WIDTH);
   localparam int unsigned WIDX_W = ADDR_WIDTH - LSB;
   localparam int unsigned WORDS  = 1 << WIDX_W;
   localparam int unsigned RW     = resp_w(ID_WIDTH, DATA_WIDTH);
   localparam int unsigned CW     = cred_w(RESP_FIFO_DEPTH);
   localparam int unsigned NSTG   = READ_LATENCY - 1;

   logic                  run_q, err_q;
   logic [CW-1:0]         cred_q, cred_d;
   logic                  wr_acc, rd_acc, pop, resp_valid;
   logic [WIDX_W-1:0]     widx;
   logic [DATA_WIDTH-1:0] mem [WORDS];
   logic [RW-1:0]         stg_q [NSTG];
   logic [NSTG-1:0]       stg_vld_q;
   logic [RW-1:0]         fifo_out;
   logic                  unused_addr_lsb;

   assign widx            = bus.cmd_addr[ADDR_WIDTH-1:LSB];
   assign unused_addr_lsb = ^bus.cmd_addr[LSB-1:0];

   // Ready is a pure function of state so the arbiter may wait on it combinationally.
   assign bus.cmd_ready = run_q && (cred_q < CW'(RESP_FIFO_DEPTH));
   assign wr_acc        = bus.cmd_ready && bus.cmd_wr_en;
   assign rd_acc        = bus.cmd_ready && bus.cmd_rd_en && !bus.cmd_wr_en;
   assign pop           = resp_valid && bus.rd_resp_ready;
   assign err_collide   = err_q;

   // Storage and read data path carry no reset so memory survives rst.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
            if (bus.cmd_wr_strb[i]) mem[widx][8*i +: 8] <= bus.cmd_wr_data[8*i +: 8];
         end
      end
      stg_q[0] <= {bus.cmd_id, mem[widx], bus.cmd_last};
      for (int unsigned s = 1; s < NSTG; s++) stg_q[s] <= stg_q[s-1];
   end

   always_comb begin
      cred_d = cred_q;
      case ({rd_acc, pop})
         2'b10:   cred_d = cred_q + CW'(1);
         2'b01:   cred_d = cred_q - CW'(1);
         default: cred_d = cred_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_q     <= 1'b0;
         err_q     <= 1'b0;
         cred_q    <= '0;
         stg_vld_q <= '0;
      end else begin
         run_q  <= 1'b1;
         cred_q <= cred_d;
         if (wr_acc && bus.cmd_rd_en) err_q <= 1'b1;
         stg_vld_q[0] <= rd_acc;
         for (int unsigned s = 1; s < NSTG; s++) stg_vld_q[s] <= stg_vld_q[s-1];
      end
   end

   axi_ram_resp_fifo #(
      .WIDTH(RW),
      .DEPTH(RESP_FIFO_DEPTH)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (stg_vld_q[NSTG-1]),
      .push_data (stg_q[NSTG-1]),
      .out_valid (resp_valid),
      .out_data  (fifo_out),
      .out_ready (bus.rd_resp_ready)
   );

   assign bus.rd_resp_valid = resp_valid;
   assign {bus.rd_resp_id, bus.rd_resp_data, bus.rd_resp_last} = fifo_out;
endmodule
